// File: rtl/local_mem_avmm_pipeline_bridge.sv
// Avalon-MM pipeline bridge between an AFU master and a local-memory bank.
// Command path: output register plus skid register; read responses: one register stage.
module local_mem_avmm_pipeline_bridge #(
    parameter int DATA_WIDTH       = 512,
    parameter int SYMBOL_WIDTH     = 8,
    parameter int HDL_ADDR_WIDTH   = 27,
    parameter int BURSTCOUNT_WIDTH = 7,
    parameter int RESPONSE_WIDTH   = 2
) (
    input  logic                                 clk,
    input  logic                                 reset_n,

    output logic                                 s0_waitrequest,
    output logic [DATA_WIDTH-1:0]                s0_readdata,
    output logic                                 s0_readdatavalid,
    output logic [RESPONSE_WIDTH-1:0]            s0_response,
    input  logic [BURSTCOUNT_WIDTH-1:0]          s0_burstcount,
    input  logic [DATA_WIDTH-1:0]                s0_writedata,
    input  logic [HDL_ADDR_WIDTH-1:0]            s0_address,
    input  logic                                 s0_write,
    input  logic                                 s0_read,
    input  logic [DATA_WIDTH/SYMBOL_WIDTH-1:0]   s0_byteenable,
    input  logic                                 s0_debugaccess,

    input  logic                                 m0_waitrequest,
    input  logic [DATA_WIDTH-1:0]                m0_readdata,
    input  logic                                 m0_readdatavalid,
    input  logic [RESPONSE_WIDTH-1:0]            m0_response,
    output logic [BURSTCOUNT_WIDTH-1:0]          m0_burstcount,
    output logic [DATA_WIDTH-1:0]                m0_writedata,
    output logic [HDL_ADDR_WIDTH-1:0]            m0_address,
    output logic                                 m0_write,
    output logic                                 m0_read,
    output logic [DATA_WIDTH/SYMBOL_WIDTH-1:0]   m0_byteenable,
    output logic                                 m0_debugaccess
);

    localparam int BE_W = DATA_WIDTH / SYMBOL_WIDTH;

    typedef struct packed {
        logic                        read;
        logic                        write;
        logic [HDL_ADDR_WIDTH-1:0]   address;
        logic [BURSTCOUNT_WIDTH-1:0] burstcount;
        logic [DATA_WIDTH-1:0]       writedata;
        logic [BE_W-1:0]             byteenable;
        logic                        debugaccess;
    } cmd_t;

    cmd_t in_cmd;
    cmd_t out_q, out_d;
    cmd_t skid_q, skid_d;
    logic out_valid_q, out_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic wait_q;

    logic [DATA_WIDTH-1:0]     rdata_q;
    logic                      rdv_q;
    logic [RESPONSE_WIDTH-1:0] resp_q;

    logic accept;
    logic consume;

    assign in_cmd = '{
        read:        s0_read,
        write:       s0_write,
        address:     s0_address,
        burstcount:  s0_burstcount,
        writedata:   s0_writedata,
        byteenable:  s0_byteenable,
        debugaccess: s0_debugaccess
    };

    assign accept  = (s0_read | s0_write) & ~wait_q;
    assign consume = out_valid_q & ~m0_waitrequest;

    // wait_q mirrors skid occupancy (and is set in reset), so accept never
    // coincides with an occupied skid register.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (consume) begin
            out_valid_d = 1'b0;
        end
        if (skid_valid_q) begin
            if (consume) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || consume) begin
                out_d       = in_cmd;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = in_cmd;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            wait_q       <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            wait_q       <= skid_valid_d;
        end
    end

    // Response path has no backpressure; it is simply delayed one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdv_q   <= 1'b0;
            rdata_q <= '0;
            resp_q  <= '0;
        end else begin
            rdv_q   <= m0_readdatavalid;
            rdata_q <= m0_readdata;
            resp_q  <= m0_response;
        end
    end

    assign s0_waitrequest   = wait_q;
    assign s0_readdatavalid = rdv_q;
    assign s0_readdata      = rdata_q;
    assign s0_response      = resp_q;

    assign m0_read        = out_q.read & out_valid_q;
    assign m0_write       = out_q.write & out_valid_q;
    assign m0_address     = out_q.address;
    assign m0_burstcount  = out_q.burstcount;
    assign m0_writedata   = out_q.writedata;
    assign m0_byteenable  = out_q.byteenable;
    assign m0_debugaccess = out_q.debugaccess;

endmodule

// File: tb/tb_local_mem_avmm_pipeline_bridge.sv
// Directed bench for local_mem_avmm_pipeline_bridge: reset, single write, read burst,
// backpressure through the skid register, short random stress and mid-traffic reset.
module tb_local_mem_avmm_pipeline_bridge;

    localparam int DW  = 512;
    localparam int BEW = 64;
    localparam int AW  = 27;
    localparam int BW  = 7;
    localparam int RW  = 2;

    logic           clk;
    logic           reset_n;
    logic           s0_waitrequest;
    logic [DW-1:0]  s0_readdata;
    logic           s0_readdatavalid;
    logic [RW-1:0]  s0_response;
    logic [BW-1:0]  s0_burstcount;
    logic [DW-1:0]  s0_writedata;
    logic [AW-1:0]  s0_address;
    logic           s0_write;
    logic           s0_read;
    logic [BEW-1:0] s0_byteenable;
    logic           s0_debugaccess;
    logic           m0_waitrequest;
    logic [DW-1:0]  m0_readdata;
    logic           m0_readdatavalid;
    logic [RW-1:0]  m0_response;
    logic [BW-1:0]  m0_burstcount;
    logic [DW-1:0]  m0_writedata;
    logic [AW-1:0]  m0_address;
    logic           m0_write;
    logic           m0_read;
    logic [BEW-1:0] m0_byteenable;
    logic           m0_debugaccess;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    local_mem_avmm_pipeline_bridge dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .s0_waitrequest   (s0_waitrequest),
        .s0_readdata      (s0_readdata),
        .s0_readdatavalid (s0_readdatavalid),
        .s0_response      (s0_response),
        .s0_burstcount    (s0_burstcount),
        .s0_writedata     (s0_writedata),
        .s0_address       (s0_address),
        .s0_write         (s0_write),
        .s0_read          (s0_read),
        .s0_byteenable    (s0_byteenable),
        .s0_debugaccess   (s0_debugaccess),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m0_response      (m0_response),
        .m0_burstcount    (m0_burstcount),
        .m0_writedata     (m0_writedata),
        .m0_address       (m0_address),
        .m0_write         (m0_write),
        .m0_read          (m0_read),
        .m0_byteenable    (m0_byteenable),
        .m0_debugaccess   (m0_debugaccess)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] %s check error", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] a,
                                 input logic [BW-1:0] b, input logic [DW-1:0] d);
        s0_read       = rd;
        s0_write      = wr;
        s0_address    = a;
        s0_burstcount = b;
        s0_writedata  = d;
        s0_byteenable = '1;
    endtask

    function automatic logic [75:0] cmdKey(input logic rd, input logic wr, input logic [AW-1:0] a,
                                           input logic [BW-1:0] b, input logic [31:0] d,
                                           input logic [7:0] be);
        return {rd, wr, a, b, d, be};
    endfunction

    logic [75:0]   sbQ[$];
    logic [75:0]   expKey;
    logic          pend;
    logic          pendRw;
    logic          acceptedNow;
    logic          expRdv;
    logic [DW-1:0] expData;
    logic [RW-1:0] expResp;
    logic [31:0]   word;

    initial begin
        reset_n          = 1'b0;
        m0_waitrequest   = 1'b0;
        m0_readdata      = '0;
        m0_readdatavalid = 1'b0;
        m0_response      = '0;
        s0_debugaccess   = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);

        // Reset held for five edges
        repeat (5) tick();
        checkOutput("rst_wait",  DW'(s0_waitrequest), DW'(1));
        checkOutput("rst_m0rd",  DW'(m0_read), DW'(0));
        checkOutput("rst_m0wr",  DW'(m0_write), DW'(0));
        checkOutput("rst_rdv",   DW'(s0_readdatavalid), DW'(0));
        checkOutput("rst_addr",  DW'(m0_address), DW'(0));
        reset_n = 1'b1;
        checkOutput("rel_wait_pre", DW'(s0_waitrequest), DW'(1));
        tick();
        checkOutput("rel_wait", DW'(s0_waitrequest), DW'(0));

        // Single write with debugaccess
        applyStimulus(1'b0, 1'b1, 27'h123, 7'd1, {16{32'hA5A5_1234}});
        s0_debugaccess = 1'b1;
        checkOutput("wr1_pre", DW'(m0_write), DW'(0));
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        s0_debugaccess = 1'b0;
        checkOutput("wr1_m0wr",  DW'(m0_write), DW'(1));
        checkOutput("wr1_m0rd",  DW'(m0_read), DW'(0));
        checkOutput("wr1_addr",  DW'(m0_address), DW'(27'h123));
        checkOutput("wr1_data",  m0_writedata, {16{32'hA5A5_1234}});
        checkOutput("wr1_burst", DW'(m0_burstcount), DW'(1));
        checkOutput("wr1_be",    DW'(m0_byteenable), DW'({BEW{1'b1}}));
        checkOutput("wr1_dbg",   DW'(m0_debugaccess), DW'(1));
        tick();
        checkOutput("wr1_done", DW'(m0_write), DW'(0));

        // Read burst of four beats
        applyStimulus(1'b1, 1'b0, 27'h40, 7'd4, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("rd_m0rd",  DW'(m0_read), DW'(1));
        checkOutput("rd_addr",  DW'(m0_address), DW'(27'h40));
        checkOutput("rd_burst", DW'(m0_burstcount), DW'(4));
        tick();
        checkOutput("rd_done", DW'(m0_read), DW'(0));
        for (int i = 0; i < 4; i++) begin
            m0_readdatavalid = 1'b1;
            m0_readdata      = {16{32'hD000_0000 + 32'(i)}};
            m0_response      = RW'(i);
            checkOutput("rd_beat_lat", DW'(s0_readdatavalid), DW'(i != 0));
            tick();
            checkOutput("rd_beat_rdv",  DW'(s0_readdatavalid), DW'(1));
            checkOutput("rd_beat_data", s0_readdata, {16{32'hD000_0000 + 32'(i)}});
            checkOutput("rd_beat_resp", DW'(s0_response), DW'(i));
        end
        m0_readdatavalid = 1'b0;
        tick();
        checkOutput("rd_end_rdv", DW'(s0_readdatavalid), DW'(0));

        // Backpressure: three writes against a stalled memory
        m0_waitrequest = 1'b1;
        applyStimulus(1'b0, 1'b1, 27'h200, 7'd1, {16{32'hB1B1_0001}});
        tick();
        checkOutput("bp1_m0wr", DW'(m0_write), DW'(1));
        checkOutput("bp1_addr", DW'(m0_address), DW'(27'h200));
        checkOutput("bp1_wait", DW'(s0_waitrequest), DW'(0));
        applyStimulus(1'b0, 1'b1, 27'h201, 7'd1, {16{32'hB2B2_0002}});
        tick();
        checkOutput("bp2_wait", DW'(s0_waitrequest), DW'(1));
        checkOutput("bp2_addr", DW'(m0_address), DW'(27'h200));
        checkOutput("bp2_data", m0_writedata, {16{32'hB1B1_0001}});
        applyStimulus(1'b0, 1'b1, 27'h202, 7'd1, {16{32'hB3B3_0003}});
        tick();
        checkOutput("bp3_wait", DW'(s0_waitrequest), DW'(1));
        checkOutput("bp3_addr", DW'(m0_address), DW'(27'h200));
        tick();
        checkOutput("bp4_addr", DW'(m0_address), DW'(27'h200));
        checkOutput("bp4_m0wr", DW'(m0_write), DW'(1));
        m0_waitrequest = 1'b0;
        tick();
        checkOutput("bp5_addr", DW'(m0_address), DW'(27'h201));
        checkOutput("bp5_data", m0_writedata, {16{32'hB2B2_0002}});
        checkOutput("bp5_wait", DW'(s0_waitrequest), DW'(0));
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("bp6_addr", DW'(m0_address), DW'(27'h202));
        checkOutput("bp6_data", m0_writedata, {16{32'hB3B3_0003}});
        checkOutput("bp6_m0wr", DW'(m0_write), DW'(1));
        tick();
        checkOutput("bp7_m0wr", DW'(m0_write), DW'(0));

        // Random stress with a queue scoreboard
        pend   = 1'b0;
        pendRw = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (!pend && ($urandom_range(0, 9) < 6)) begin
                pend   = 1'b1;
                pendRw = 1'($urandom_range(0, 1));
                word   = $urandom;
                applyStimulus(pendRw, ~pendRw, AW'($urandom), BW'($urandom_range(1, 8)), {16{word}});
            end else if (!pend) begin
                applyStimulus(1'b0, 1'b0, '0, '0, '0);
            end
            m0_waitrequest   = 1'($urandom_range(0, 1));
            m0_readdatavalid = 1'($urandom_range(0, 1));
            m0_readdata      = {16{$urandom}};
            m0_response      = RW'($urandom_range(0, 3));
            if ((m0_read | m0_write) && !m0_waitrequest) begin
                expKey = (sbQ.size() != 0) ? sbQ.pop_front() : '0;
                checkOutput("stress_cmd",
                            DW'(cmdKey(m0_read, m0_write, m0_address, m0_burstcount,
                                       m0_writedata[31:0], m0_byteenable[7:0])),
                            DW'(expKey));
            end
            acceptedNow = pend && !s0_waitrequest;
            if (acceptedNow) begin
                sbQ.push_back(cmdKey(s0_read, s0_write, s0_address, s0_burstcount,
                                     s0_writedata[31:0], 8'hFF));
            end
            expRdv  = m0_readdatavalid;
            expData = m0_readdata;
            expResp = m0_response;
            tick();
            checkOutput("stress_rdv", DW'(s0_readdatavalid), DW'(expRdv));
            if (expRdv) begin
                checkOutput("stress_rdata", s0_readdata, expData);
                checkOutput("stress_resp",  DW'(s0_response), DW'(expResp));
            end
            if (acceptedNow) begin
                pend = 1'b0;
            end
        end
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        m0_waitrequest   = 1'b0;
        m0_readdatavalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m0_read | m0_write) begin
                expKey = (sbQ.size() != 0) ? sbQ.pop_front() : '0;
                checkOutput("drain_cmd",
                            DW'(cmdKey(m0_read, m0_write, m0_address, m0_burstcount,
                                       m0_writedata[31:0], m0_byteenable[7:0])),
                            DW'(expKey));
            end
            tick();
        end
        checkOutput("drain_empty", DW'(sbQ.size()), DW'(0));
        checkOutput("drain_idle",  DW'(m0_read | m0_write), DW'(0));

        // Reset while the skid register is occupied
        m0_waitrequest = 1'b1;
        applyStimulus(1'b0, 1'b1, 27'h300, 7'd1, {16{32'hC0C0_0300}});
        tick();
        applyStimulus(1'b0, 1'b1, 27'h301, 7'd1, {16{32'hC1C1_0301}});
        tick();
        checkOutput("mr_skid_wait", DW'(s0_waitrequest), DW'(1));
        checkOutput("mr_m0wr_pre",  DW'(m0_write), DW'(1));
        reset_n = 1'b0;
        #1;
        checkOutput("mr_async_m0wr", DW'(m0_write), DW'(0));
        checkOutput("mr_async_wait", DW'(s0_waitrequest), DW'(1));
        checkOutput("mr_async_addr", DW'(m0_address), DW'(0));
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        m0_waitrequest = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checkOutput("mr_rel_wait", DW'(s0_waitrequest), DW'(0));
        checkOutput("mr_rel_m0wr", DW'(m0_write), DW'(0));
        tick();
        checkOutput("mr_rel_m0wr2", DW'(m0_write), DW'(0));
        checkOutput("mr_rel_m0rd",  DW'(m0_read), DW'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/local_mem_avmm_pipeline_bridge.md
Name:
local_mem_avmm_pipeline_bridge

Overview:
- Avalon-MM pipeline bridge between an AFU-side master (s0) and the local-memory DDR4 EMIF model (m0).
- Registers the command path through a 2-entry skid buffer, so s0_waitrequest never depends combinationally on m0_waitrequest.
- Registers the read-response path by one stage.
- Removes misaligned-edge glitches from the memory model; one instance per memory bank.

Parameters:
DATA_WIDTH, 512, data bus width in bits
SYMBOL_WIDTH, 8, bits per byteenable lane; byteenable width BE_W = DATA_WIDTH/SYMBOL_WIDTH
HDL_ADDR_WIDTH, 27, word address width
BURSTCOUNT_WIDTH, 7, burstcount width
RESPONSE_WIDTH, 2, response code width

Ports:
clk  in  1  bridge clock (memory-bank clock)
reset_n  in  1  asynchronous active-low reset
s0_waitrequest  out  1  command stall to upstream master
s0_readdata  out  DATA_WIDTH  read data
s0_readdatavalid  out  1  read data beat valid
s0_response  out  RESPONSE_WIDTH  response code for the read beat
s0_burstcount  in  BURSTCOUNT_WIDTH  burst length
s0_writedata  in  DATA_WIDTH  write data
s0_address  in  HDL_ADDR_WIDTH  word address
s0_write  in  1  write request
s0_read  in  1  read request
s0_byteenable  in  BE_W  byte enables
s0_debugaccess  in  1  debug flag, passed through
m0_waitrequest  in  1  downstream stall
m0_readdata  in  DATA_WIDTH  downstream read data
m0_readdatavalid  in  1  downstream read beat valid
m0_response  in  RESPONSE_WIDTH  downstream response; X tolerated
m0_burstcount  out  BURSTCOUNT_WIDTH  forwarded burst length
m0_writedata  out  DATA_WIDTH  forwarded write data
m0_address  out  HDL_ADDR_WIDTH  forwarded address
m0_write  out  1  forwarded write
m0_read  out  1  forwarded read
m0_byteenable  out  BE_W  forwarded byte enables
m0_debugaccess  out  1  forwarded debug flag

Behaviour:
- Reset (reset_n low, async): all valid flags 0; m0_read, m0_write and s0_readdatavalid low; all data, address and control registers 0; s0_waitrequest=1.
- Reset release: s0_waitrequest drops to 0 on the first clk rising edge with reset_n high.
- Reset mid-operation: in-flight commands and responses are discarded without being issued.
- Command accept: beat accepted when (s0_read|s0_write) & !s0_waitrequest. It captures read, write, address, burstcount, writedata, byteenable and debugaccess.
- Output stage holds one command. m0_read/m0_write equal the captured flags gated by the output-valid flag. m0 fields are driven from this register only; no combinational s0 to m0 path.
- Output stage is consumed when valid & !m0_waitrequest.
- Load rules:
  - Output empty, or consumed this cycle: accepted beat loads the output stage directly. Latency is 1 cycle from accept to m0 presentation.
  - Output full and not consumed: accepted beat goes to the skid register, and s0_waitrequest=1 from the next cycle.
  - Skid full and output consumed: skid moves to the output stage, and s0_waitrequest=0 next cycle.
- s0_waitrequest = registered skid-full flag, which equals 1 only in reset or when the skid is occupied. No beat is ever lost or duplicated. Order is strictly preserved.
- m0 command signals stay stable while m0_waitrequest=1.
- Bursts: each write beat is an independent command and carries its burstcount unchanged. A read burst is one command; its N return beats pass through the response stage.
- Response stage: m0_readdatavalid/readdata/response are registered to s0 with 1-cycle latency, no backpressure, every cycle.
- Added read latency is at least 2 cycles: 1 command plus 1 response.
- s0_read and s0_write high together is illegal upstream. The bridge forwards both flags exactly as captured; no arbitration.
- Accept while idle inputs (no read/write): nothing captured.

Test Plan:
- Reset: hold reset_n=0 over 5 clks -> s0_waitrequest=1, m0_read=m0_write=0, s0_readdatavalid=0; first edge after release -> s0_waitrequest=0.
- Single write: addr=0x123, data=pattern A, be=all-ones, burst=1, m0_waitrequest=0 -> m0_write=1 with identical fields exactly 1 cycle later, for 1 cycle.
- Read burst: read addr=0x40 burst=4; m0 returns 4 readdatavalid beats D0..D3 -> s0_readdatavalid beats D0..D3 each delayed 1 cycle, same order.
- Backpressure: hold m0_waitrequest=1 while issuing 3 write beats -> second beat lands in skid and s0_waitrequest=1; m0 fields stable; on release all 3 beats appear in order, none lost or duplicated.
- Random stress: random m0_waitrequest at 50%, random read/write mix -> m0 command stream equals the s0 accepted stream; s0 response stream equals m0 response stream shifted 1 cycle.
- Mid-traffic reset: assert reset_n=0 with skid full -> outputs return to reset values immediately (async), no stale command issued after release.
